dmem_bank: RTL and testbench
============================

Name: dmem_bank

Overview:
- Parametrised successor of the single-port byte-write data memory.
- Word-organised synchronous RAM behind a valid/ready request and response handshake.
- Generates byte lanes internally from access size and address offset.
- Returns aligned, sign- or zero-extended load data for the RV32 load/store unit; one request per cycle, read latency 1.

Parameters:
- ADDR_W, 32: width of req_addr.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 4.
- IDX_W, $clog2(DEPTH_WORDS): derived word-index width; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and word loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when high together with resp_valid
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  access error (see Optional Feature)

Behaviour:
- Reset:
  - Synchronous, active-low, on clk rising edge.
  - Clears resp_valid, resp_rdata and resp_err to 0.
  - Array contents are not reset.
- Accept and ready:
  - A request is accepted on any edge with req_valid && req_ready.
  - req_ready = rst_n && (!resp_valid || resp_ready), which is combinational.
  - Sustained throughput is 1 request per cycle.
- Word index: req_addr[IDX_W+1:2]. Upper address bits are ignored, so accesses alias modulo DEPTH_WORDS*4.
- Store lanes:
  - byte: lane = 1 << addr[1:0]; wdata[7:0] replicated to all lanes.
  - half: lanes = 4'b0011 << (2*addr[1]); wdata[15:0] replicated.
  - word: lanes = 4'b1111.
  - Only enabled lanes are written, at the accept edge.
- Load:
  - The array word is read at the accept edge.
  - Offset, size and unsigned are registered alongside the read.
  - Extraction and extension produce resp_rdata, visible with resp_valid in the next cycle (latency 1).
  - Byte load selects bits [8*off+7:8*off]; half load selects [16*addr[1]+15:16*addr[1]].
  - The result is sign-extended unless req_unsigned = 1.
- Store response: resp_valid rises the cycle after accept, with resp_rdata = 0.
- Response hold:
  - resp_valid, resp_rdata and resp_err hold stable while resp_valid && !resp_ready.
  - When a response is consumed and a new request is accepted on the same edge, the new response replaces it with no bubble.
- Hazards:
  - A load accepted the cycle after a store to the same word returns the new data.
  - Only one access is accepted per cycle, so there is no port conflict.
- Reset mid-operation:
  - A pending response is dropped.
  - No write occurs on any edge where rst_n = 0, even if req_valid = 1.
- Idle: when nothing is accepted and the response is consumed, resp_valid goes low. resp_rdata keeps its last value.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - resp_err = 1 for a misaligned half (addr[0] = 1) or word (addr[1:0] != 0) access.
  - resp_err = 1 when req_addr >= DEPTH_WORDS*4.
  - An erroring store writes nothing.
  - An erroring load returns resp_rdata = 0.
  - Timing and handshake are unchanged.
- Undefined:
  - resp_err is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - Out-of-range addresses alias.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then LW 0x10 → resp_rdata = 0xDEADBEEF, one cycle after the load is accepted.
- SB 0x80 at 0x13 over word 0x00000000; LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80000000.
- SH 0xBEEF at 0x22; LH 0x22 → 0xFFFFBEEF; LHU 0x22 → 0x0000BEEF; lower half of word 0x20 unchanged.
- Back-to-back loads with resp_ready held low for 3 cycles:
  - req_ready = 0 while the response is held;
  - the first response holds stable;
  - both responses arrive in order with no loss.
- rst_n low for 1 cycle while a store to 0x40 is presented and a response is pending:
  - resp_valid = 0 after reset;
  - a later LW 0x40 returns the prior contents.
- With DMEM_ERR_EN defined:
  - LW 0x42 → resp_err = 1, rdata = 0.
  - SW at DEPTH_WORDS*4 → resp_err = 1; word 0 unchanged.

Source files
------------

// File: rtl/dmem_bank.sv
// Word-organised byte-lane data RAM with valid/ready request/response, read latency 1.
// Define DMEM_ERR_EN to flag misaligned and out-of-range accesses on resp_err.
module dmem_bank #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             err_c;
  logic [3:0]       lanes;
  logic [31:0]      wdata_rep;

  logic        resp_valid_q, resp_valid_d;
  logic        is_load_q, is_load_d;
  logic        err_q, err_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rd_word_q;

  assign req_ready = rst_n && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
  always_comb begin
    err_c = |req_addr[ADDR_W-1:IDX_W+2];
    unique case (1'b1)
      req_size == 2'd0: ;
      req_size == 2'd1: err_c = err_c | req_addr[0];
      default:          err_c = err_c | (|req_addr[1:0]);
    endcase
  end
`else
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];
  assign err_c       = 1'b0;
`endif

  always_comb begin
    lanes     = 4'b1111;
    wdata_rep = req_wdata;
    unique case (1'b1)
      req_size == 2'd0: begin
        lanes     = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      req_size == 2'd1: begin
        lanes     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q && !resp_ready;
    is_load_d    = is_load_q;
    err_d        = err_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      is_load_d    = !req_we;
      err_d        = err_c;
      off_d        = req_addr[1:0];
      size_d       = req_size;
      uns_d        = req_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      is_load_q    <= 1'b0;
      err_q        <= 1'b0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      is_load_q    <= is_load_d;
      err_q        <= err_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  // accept is already gated by rst_n through req_ready
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_q <= mem[idx];
      if (req_we && !err_c) begin
        for (int i = 0; i < 4; i++) begin
          if (lanes[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  logic [31:0] sh_b;
  logic [15:0] sh_h;

  always_comb begin
    sh_b       = rd_word_q >> {off_q, 3'b000};
    sh_h       = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    resp_rdata = rd_word_q;
    unique case (1'b1)
      size_q == 2'd0:
        resp_rdata = {{24{sh_b[7] & !uns_q}}, sh_b[7:0]};
      size_q == 2'd1:
        resp_rdata = {{16{sh_h[15] & !uns_q}}, sh_h};
      default: ;
    endcase
    if (!is_load_q || err_q) resp_rdata = 32'd0;
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_bank.sv
// Directed self-checking bench for dmem_bank.
// Run with +define+DMEM_ERR_EN to exercise the error path.
module tb_dmem_bank;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bank #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // One accepted request with resp_ready high; returns at the negedge
  // where its response is visible.
  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", resp_err); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word();
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sw_valid got %b exp 1", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL sw_rdata got %h exp 0", resp_rdata); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %b exp 1", resp_valid); end
    checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_word got %h exp deadbeef", resp_rdata); end
  endtask

  task automatic test_byte();
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    checks++; if (resp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h exp ffffff80", resp_rdata); end
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    checks++; if (resp_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu got %h exp 00000080", resp_rdata); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checks++; if (resp_rdata !== 32'h80000000) begin errors++; $display("FAIL lw_after_sb got %h exp 80000000", resp_rdata); end
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    checks++; if (resp_rdata !== 32'h00000000) begin errors++; $display("FAIL lb_other_lane got %h exp 0", resp_rdata); end
  endtask

  task automatic test_half();
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    checks++; if (resp_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh got %h exp ffffbeef", resp_rdata); end
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    checks++; if (resp_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL lhu got %h exp 0000beef", resp_rdata); end
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    checks++; if (resp_rdata !== 32'hBEEF5678) begin errors++; $display("FAIL lw_after_sh got %h exp beef5678", resp_rdata); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h11111111);
    do_req(1'b1, 2'd2, 1'b0, 32'h34, 32'h22222222);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h30;
    resp_ready = 1'b0;
    @(posedge clk);
    #1 req_addr = 32'h34;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11111111) begin
        errors++; $display("FAIL hold_%0d got %b/%h exp 1/11111111", i, resp_valid, resp_rdata);
      end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d got %b exp 0", i, req_ready); end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h22222222) begin
      errors++; $display("FAIL second_resp got %b/%h exp 1/22222222", resp_valid, resp_rdata);
    end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h22222222) begin
      errors++; $display("FAIL idle got %b/%h exp 0/22222222", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h50; req_wdata = 32'hCAFEF00D; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL st_resp got %b/%h exp 1/0", resp_valid, resp_rdata);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL raw got %b/%h exp 1/cafef00d", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
    resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL pend_valid got %b exp 1", resp_valid); end
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", resp_valid); end
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    checks++; if (resp_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL mid_rst_data got %h exp a5a5a5a5", resp_rdata); end
  endtask

  task automatic test_err();
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h0BADF00D);
`ifdef DMEM_ERR_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL lw_misalign got %b/%h exp 1/0", resp_err, resp_rdata);
    end
    do_req(1'b1, 2'd2, 1'b0, DEPTH * 4, 32'h5A5A5A5A);
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL sw_oor got %b exp 1", resp_err); end
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL word0 got %b/%h exp 0/0badf00d", resp_err, resp_rdata);
    end
`else
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL lw_unaligned got %b/%h exp 0/a5a5a5a5", resp_err, resp_rdata);
    end
    do_req(1'b1, 2'd2, 1'b0, DEPTH * 4, 32'h5A5A5A5A);
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL sw_alias_err got %b exp 0", resp_err); end
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checks++; if (resp_rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL alias got %h exp 5a5a5a5a", resp_rdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
